picomem_arbiter2: RTL and testbench
===================================

PICOMEM_ARBITER2 -- requirements
Module: picomem_arbiter2

Interface
REQ-001 Parameter ADDR_W, default 23, SHALL set the byte-address width of all address ports.
REQ-002 Parameter TIMEOUT_CYCLES, default 100, SHALL set the BUSY cycle count at which timeout_err sets.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 sys_resetn  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 m0_valid/m1_valid  input  1 each  SHALL be the master request, held high until that master sees its ready.
REQ-006 m0_addr/m1_addr  input  ADDR_W each  SHALL be the master byte address.
REQ-007 m0_wstrb/m1_wstrb  input  4 each  SHALL be the write strobes; 0 means read.
REQ-008 m0_wdata/m1_wdata  input  32 each  SHALL be the master write data.
REQ-009 m0_ready/m1_ready  output  1 each  SHALL be the one-cycle completion pulse to the owning master.
REQ-010 m0_rdata/m1_rdata  output  32 each  SHALL be the read data, valid while the matching ready is high.
REQ-011 mem_valid, mem_addr[ADDR_W], mem_wstrb[4], mem_wdata[32]  output  SHALL be the request to the PSRAM controller.
REQ-012 mem_ready[1], mem_rdata[32], mem_init_ready[1]  input  SHALL be the PSRAM controller response and init status.
REQ-013 grant  output  2  SHALL be one-hot current owner (bit0=m0, bit1=m1), 0 when idle.
REQ-014 timeout_err  output  1  SHALL be a sticky flag set when a transaction exceeds TIMEOUT_CYCLES.

Function
REQ-015 FSM states SHALL be IDLE, BUSY and RECOVER.
REQ-016 IDLE: no request SHALL be granted while mem_init_ready=0.
REQ-017 IDLE with mem_init_ready=1 and exactly one valid: that master SHALL be granted; next state BUSY.
REQ-018 IDLE with both valid: the master not served last SHALL be granted (round robin); pointer SHALL be updated on every grant.
REQ-019 On grant, addr/wstrb/wdata of the winner SHALL be registered into mem_addr/mem_wstrb/mem_wdata, and mem_valid SHALL go high on the same edge, i.e. one cycle after IDLE sees valid.
REQ-020 mem_addr/mem_wstrb/mem_wdata SHALL stay constant while mem_valid=1.
REQ-021 BUSY: on mem_ready=1, the owner's mX_ready SHALL be high combinationally in that cycle, mX_rdata SHALL equal mem_rdata, and on that edge mem_valid SHALL go 0, grant SHALL go 0, next state RECOVER.
REQ-022 The non-owner's ready SHALL be 0 at all times; mX_rdata for the non-owner SHALL be 0.
REQ-023 mem_ready seen outside BUSY SHALL be ignored, and no mX_ready SHALL be generated.
REQ-024 RECOVER SHALL last exactly one cycle, with no grant, so the served master drops valid; next state IDLE.
REQ-025 Minimum master-visible latency SHALL be controller latency + 1 cycle, and back-to-back throughput SHALL be one request per controller latency + 3 cycles.
REQ-026 A 16-bit BUSY cycle counter SHALL clear on grant and saturate; on reaching TIMEOUT_CYCLES it SHALL set timeout_err, and the FSM SHALL keep waiting with no abort.
REQ-027 A master dropping valid while BUSY SHALL NOT abort the memory transaction; its ready pulse SHALL still be issued.
REQ-028 Requests from the master not granted SHALL be held off, with no side effects, until re-arbitration in IDLE.

Reset
REQ-029 Asserting sys_resetn=0 SHALL immediately force IDLE, mem_valid=0, mem_addr=0, mem_wstrb=0, mem_wdata=0, grant=0, timeout_err=0, counter=0, and last-served pointer=m1 so that m0 wins the first tie.
REQ-030 Reset asserted mid-transaction SHALL drop mem_valid without issuing any mX_ready.
REQ-031 Reset release SHALL be synchronised internally, and the first grant SHALL occur no earlier than the second edge after release.

Structure
REQ-032 FSM state encodings and the default TIMEOUT_CYCLES SHALL live in the shared package picomem_pkg.
REQ-033 Round-robin selection SHALL be a sub-module rr_pick2 with inputs req[2] and last, and output gnt[2].

Verification
REQ-034 mem_init_ready=0, m0_valid=1 for 50 cycles -> mem_valid stays 0; raise init_ready -> mem_valid=1 next cycle with mem_addr=m0_addr.
REQ-035 m0 write addr=0x000004, wstrb=4'b1111, wdata=0x117733C7, controller ready after 10 cycles -> m0_ready one pulse, m1_ready=0, grant back to 0, RECOVER one cycle.
REQ-036 Both masters valid continuously from reset -> grants alternate m0, m1, m0, m1, with no two consecutive grants to the same master.
REQ-037 m1 read, mem_rdata=0xFFFF77FF with ready -> m1_rdata=0xFFFF77FF in the same cycle as m1_ready.
REQ-038 Controller never asserts ready -> timeout_err=1 at cycle 100 of BUSY and stays 1; a later ready completes normally.
REQ-039 sys_resetn pulsed low while BUSY -> mem_valid=0 asynchronously, no mX_ready, and the next tie is granted to m0.

Source files
------------

// File: rtl/picomem_pkg.sv
// Shared definitions for the PSRAM two-master arbiter.
package picomem_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RECOVER = 2'd2
    } arb_state_t;

    // Default number of BUSY cycles after which timeout_err is raised.
    localparam int TIMEOUT_CYCLES_DEF = 100;

    // Width of the saturating BUSY-cycle counter.
    localparam int CNT_W = 16;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// master that was not served last (last=1 means m1 was served last).
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Purely combinational winner selection.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/picomem_arbiter2.sv
// Two-master arbiter in front of a single PSRAM controller port.
// One transaction at a time: IDLE arbitrates, BUSY waits for the
// controller, RECOVER gives the served master one cycle to drop valid.
module picomem_arbiter2
    import picomem_pkg::*;
#(
    parameter int ADDR_W         = 23,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              sys_resetn,
    input  logic              m0_valid,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [3:0]        m0_wstrb,
    input  logic [31:0]       m0_wdata,
    output logic              m0_ready,
    output logic [31:0]       m0_rdata,
    input  logic              m1_valid,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [3:0]        m1_wstrb,
    input  logic [31:0]       m1_wdata,
    output logic              m1_ready,
    output logic [31:0]       m1_rdata,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_init_ready,
    output logic [1:0]        grant,
    output logic              timeout_err
);

    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

    logic [1:0]       rst_sync;
    logic             rst_n;
    arb_state_t       state_q;
    arb_state_t       state_d;
    logic             grant_evt;
    logic             done_evt;
    logic [1:0]       pick_req;
    logic [1:0]       pick_gnt;
    logic             last_m1;
    logic [CNT_W-1:0] busy_cnt;
    logic [CNT_W-1:0] cnt_inc;

    // Reset asserts immediately but releases only after two clock edges.
    always_ff @(posedge clk or negedge sys_resetn) begin
        if (!sys_resetn) rst_sync <= 2'b00;
        else             rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    // Requests are only eligible once the controller has finished init.
    assign pick_req = {m1_valid, m0_valid} & {2{mem_init_ready}};

    rr_pick2 u_pick (
        .req  (pick_req),
        .last (last_m1),
        .gnt  (pick_gnt)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic plus the grant / completion strobes.
    always_comb begin
        state_d   = state_q;
        grant_evt = 1'b0;
        done_evt  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|pick_gnt) begin
                    state_d   = ST_BUSY;
                    grant_evt = 1'b1;
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    state_d  = ST_RECOVER;
                    done_evt = 1'b1;
                end
            end
            ST_RECOVER: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Completion is routed combinationally to the owner only; a mem_ready
    // outside BUSY never reaches a master.
    assign m0_ready = done_evt & grant[0];
    assign m1_ready = done_evt & grant[1];
    assign m0_rdata = m0_ready ? mem_rdata : 32'h0;
    assign m1_rdata = m1_ready ? mem_rdata : 32'h0;

    // Capture the winner's request and hold it stable until completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wstrb <= 4'h0;
            mem_wdata <= 32'h0;
            grant     <= 2'b00;
            last_m1   <= 1'b1;
        end else if (grant_evt) begin
            mem_valid <= 1'b1;
            mem_addr  <= pick_gnt[1] ? m1_addr  : m0_addr;
            mem_wstrb <= pick_gnt[1] ? m1_wstrb : m0_wstrb;
            mem_wdata <= pick_gnt[1] ? m1_wdata : m0_wdata;
            grant     <= pick_gnt;
            last_m1   <= pick_gnt[1];
        end else if (done_evt) begin
            mem_valid <= 1'b0;
            grant     <= 2'b00;
        end
    end

    assign cnt_inc = (busy_cnt == '1) ? busy_cnt : busy_cnt + CNT_W'(1);

    // Count BUSY cycles; the timeout is only reported, never aborts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt    <= '0;
            timeout_err <= 1'b0;
        end else if (grant_evt) begin
            busy_cnt <= '0;
        end else if (state_q == ST_BUSY) begin
            busy_cnt <= cnt_inc;
            if (cnt_inc >= TIMEOUT_LIM) timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_picomem_arbiter2.sv
// Self-checking bench for picomem_arbiter2: directed scenarios followed by
// randomized traffic, all checked against a transaction-level model.
module tb_picomem_arbiter2;

    localparam int AW = 23;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          sys_resetn;
    logic          m0_valid, m1_valid;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [3:0]    m0_wstrb, m1_wstrb;
    logic [31:0]   m0_wdata, m1_wdata;
    logic          m0_ready, m1_ready;
    logic [31:0]   m0_rdata, m1_rdata;
    logic          mem_valid;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_wstrb;
    logic [31:0]   mem_wdata;
    logic          mem_ready;
    logic [31:0]   mem_rdata;
    logic          mem_init_ready;
    logic [1:0]    grant;
    logic          timeout_err;

    always #5 clk = ~clk;

    picomem_arbiter2 #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .sys_resetn(sys_resetn),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_init_ready(mem_init_ready),
        .grant(grant), .timeout_err(timeout_err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Transaction-level model: who owns the memory, for how long, and
    // what request was captured.
    int            m_owner;
    bit            m_recover;
    int            m_sync;
    int            m_last;
    int            m_busy;
    bit            m_terr;
    logic [AW-1:0] m_addr;
    logic [3:0]    m_wstrb;
    logic [31:0]   m_wdata;

    // Bench controls for the memory responder and masters.
    bit          auto_mem  = 1'b0;
    bit          noise_en  = 1'b0;
    bit          rand_lat  = 1'b0;
    bit          fixed_rd  = 1'b0;
    bit          drop_en   = 1'b1;
    logic [31:0] fixed_val = 32'h0;
    int          cur_lat   = 3;

    bit          exp_r0, exp_r1;
    int          pulses0 = 0, pulses1 = 0;
    logic [31:0] cap_rdata1 = 32'h0;
    logic [1:0]  prev_grant = 2'b00;
    logic [1:0]  gq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_owner   = -1;
        m_recover = 1'b0;
        m_sync    = 0;
        m_last    = 1;
        m_busy    = 0;
        m_terr    = 1'b0;
        m_addr    = '0;
        m_wstrb   = 4'h0;
        m_wdata   = 32'h0;
    endfunction

    // Advance the model by one rising edge using the inputs present at it.
    function automatic void model_edge();
        int w;
        if (!sys_resetn) begin
            model_reset();
            return;
        end
        if (m_sync < 2) begin
            m_sync++;
            return;
        end
        if (m_owner >= 0) begin
            if (m_busy < 65535) m_busy++;
            if (m_busy >= TO) m_terr = 1'b1;
            if (mem_ready) begin
                m_owner   = -1;
                m_recover = 1'b1;
            end
        end else if (m_recover) begin
            m_recover = 1'b0;
        end else if (mem_init_ready && (m0_valid || m1_valid)) begin
            if (m0_valid && m1_valid) w = 1 - m_last;
            else                      w = m0_valid ? 0 : 1;
            m_owner = w;
            m_last  = w;
            m_busy  = 0;
            m_addr  = (w == 1) ? m1_addr  : m0_addr;
            m_wstrb = (w == 1) ? m1_wstrb : m0_wstrb;
            m_wdata = (w == 1) ? m1_wdata : m0_wdata;
            if (rand_lat) cur_lat = $urandom_range(0, 12);
        end
    endfunction

    task automatic drive_mem();
        if (!auto_mem) return;
        if (m_owner >= 0) mem_ready = (m_busy >= cur_lat);
        else              mem_ready = noise_en ? ($urandom_range(0, 3) == 0) : 1'b0;
        mem_rdata = fixed_rd ? fixed_val : $urandom;
    endtask

    task automatic compare();
        logic       e0, e1;
        logic [1:0] eg;
        e0 = (m_owner == 0) && mem_ready;
        e1 = (m_owner == 1) && mem_ready;
        eg = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
        check("m0_ready", m0_ready, e0);
        check("m1_ready", m1_ready, e1);
        check("m0_rdata", m0_rdata, e0 ? mem_rdata : 32'h0);
        check("m1_rdata", m1_rdata, e1 ? mem_rdata : 32'h0);
        check("mem_valid", mem_valid, m_owner >= 0);
        check("grant", grant, eg);
        check("mem_addr", mem_addr, m_addr);
        check("mem_wstrb", mem_wstrb, m_wstrb);
        check("mem_wdata", mem_wdata, m_wdata);
        check("timeout_err", timeout_err, m_terr);
        exp_r0 = e0;
        exp_r1 = e1;
        if (m0_ready) pulses0++;
        if (m1_ready) begin
            pulses1++;
            cap_rdata1 = m1_rdata;
        end
        if (grant != 2'b00 && prev_grant == 2'b00) gq.push_back(grant);
        prev_grant = grant;
    endtask

    // One clock: drive responder, check mid-cycle, advance model at the edge.
    task automatic step();
        drive_mem();
        #2;
        compare();
        @(posedge clk);
        model_edge();
        #1;
        if (drop_en) begin
            if (exp_r0) m0_valid = 1'b0;
            if (exp_r1) m1_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        while (m_owner >= 0 && k < 400) begin
            step();
            k++;
        end
        check(nm, k < 400, 1'b1);
    endtask

    task automatic drive_master(input int i, input bit got, inout logic v,
                                inout logic [AW-1:0] a, inout logic [3:0] s, inout logic [31:0] d);
        if (got) begin
            v = 1'b0;
        end else if (v && m_owner == i && $urandom_range(0, 29) == 0) begin
            v = 1'b0;
        end else if (!v && m_owner != i && $urandom_range(0, 2) == 0) begin
            v = 1'b1;
            a = AW'($urandom);
            s = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            d = $urandom;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_resetn = 1'b0;
        m0_valid = 1'b0; m0_addr = '0; m0_wstrb = 4'h0; m0_wdata = 32'h0;
        m1_valid = 1'b0; m1_addr = '0; m1_wstrb = 4'h0; m1_wdata = 32'h0;
        mem_ready = 1'b0; mem_rdata = 32'h0; mem_init_ready = 1'b0;
        model_reset();

        // Reset state.
        repeat (3) step();
        check("rst_mem_valid", mem_valid, 1'b0);
        check("rst_grant", grant, 2'b00);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_timeout", timeout_err, 1'b0);

        // Init gating: nothing is granted until the controller is ready.
        sys_resetn = 1'b1;
        m0_valid = 1'b1; m0_addr = 23'h00ABC0; m0_wstrb = 4'h0; m0_wdata = 32'h0;
        repeat (50) step();
        check("init_hold_mem_valid", mem_valid, 1'b0);
        mem_init_ready = 1'b1;
        step();
        check("init_mem_valid", mem_valid, 1'b1);
        check("init_mem_addr", mem_addr, 23'h00ABC0);
        check("init_grant", grant, 2'b01);
        auto_mem = 1'b1;
        cur_lat  = 3;
        wait_done("init_done");

        // m0 write with a 10-cycle controller, then the one-cycle RECOVER.
        step();
        m0_valid = 1'b1; m0_addr = 23'h000004; m0_wstrb = 4'hF; m0_wdata = 32'h117733C7;
        step();
        cur_lat = 10;
        pulses0 = 0; pulses1 = 0;
        step();
        check("wr_mem_wdata", mem_wdata, 32'h117733C7);
        check("wr_mem_wstrb", mem_wstrb, 4'hF);
        check("wr_mem_addr", mem_addr, 23'h000004);
        wait_done("wr_done");
        check("wr_m0_pulses", pulses0, 1);
        check("wr_m1_pulses", pulses1, 0);
        check("wr_grant_clear", grant, 2'b00);
        check("wr_mem_valid_clear", mem_valid, 1'b0);
        m0_valid = 1'b1; m0_addr = 23'h000008; m0_wstrb = 4'h0;
        step();
        check("recover_no_grant", mem_valid, 1'b0);
        step();
        check("recover_then_grant", mem_valid, 1'b1);
        cur_lat = 2;
        wait_done("recover_done");

        // m1 read returns controller data alongside m1_ready.
        m1_valid = 1'b1; m1_addr = 23'h000010; m1_wstrb = 4'h0; m1_wdata = 32'h0;
        fixed_rd = 1'b1; fixed_val = 32'hFFFF77FF;
        pulses1 = 0;
        repeat (3) step();
        wait_done("rd_done");
        check("rd_m1_pulses", pulses1, 1);
        check("rd_m1_rdata", cap_rdata1, 32'hFFFF77FF);
        fixed_rd = 1'b0;

        // Controller stalls: sticky timeout after 100 BUSY cycles, no abort.
        repeat (2) step();
        m0_valid = 1'b1; m0_addr = 23'h000020; m0_wstrb = 4'h3; m0_wdata = 32'hCAFE0001;
        cur_lat = 1000;
        while (m_owner < 0 && m_sync >= 2 && !m_recover && mem_valid === 1'b0 && pulses1 < 100) begin
            step();
            if (mem_valid === 1'b1) break;
            pulses1 = pulses1 + 100;
        end
        check("to_granted", grant, 2'b01);
        repeat (99) step();
        check("to_before", timeout_err, 1'b0);
        step();
        check("to_set", timeout_err, 1'b1);
        repeat (20) step();
        check("to_sticky", timeout_err, 1'b1);
        check("to_still_busy", mem_valid, 1'b1);
        pulses0 = 0;
        cur_lat = 0;
        wait_done("to_done");
        check("to_late_ready", pulses0, 1);
        check("to_sticky_after", timeout_err, 1'b1);

        // Reset asserted mid-transaction, then both masters contend.
        repeat (2) step();
        m1_valid = 1'b1; m1_addr = 23'h000030; m1_wstrb = 4'h0;
        cur_lat = 50;
        repeat (5) step();
        check("rst_mid_busy", mem_valid, 1'b1);
        auto_mem = 1'b0;
        mem_ready = 1'b1;
        sys_resetn = 1'b0;
        #1;
        check("async_mem_valid", mem_valid, 1'b0);
        check("async_grant", grant, 2'b00);
        check("async_m0_ready", m0_ready, 1'b0);
        check("async_m1_ready", m1_ready, 1'b0);
        check("async_timeout", timeout_err, 1'b0);
        model_reset();
        drop_en = 1'b0;
        m0_valid = 1'b1; m0_addr = 23'h000100; m0_wstrb = 4'h1; m0_wdata = 32'h11111111;
        m1_valid = 1'b1; m1_addr = 23'h000200; m1_wstrb = 4'h2; m1_wdata = 32'h22222222;
        repeat (2) step();
        mem_ready = 1'b0;
        auto_mem  = 1'b1;
        cur_lat   = 3;
        sys_resetn = 1'b1;
        step();
        step();
        check("sync_no_grant", mem_valid, 1'b0);
        gq.delete();
        step();
        check("first_tie_m0", grant, 2'b01);
        repeat (40) step();
        check("alt_count", gq.size() >= 4, 1'b1);
        if (gq.size() > 0) check("alt_first", gq[0], 2'b01);
        for (int i = 0; i + 1 < gq.size(); i++) check("alt_seq", gq[i] != gq[i + 1], 1'b1);

        // Randomized traffic against the model.
        drop_en  = 1'b0;
        rand_lat = 1'b1;
        noise_en = 1'b1;
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        repeat (3000) begin
            mem_init_ready = ($urandom_range(0, 9) != 0);
            step();
            drive_master(0, exp_r0, m0_valid, m0_addr, m0_wstrb, m0_wdata);
            drive_master(1, exp_r1, m1_valid, m1_addr, m1_wstrb, m1_wdata);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
